// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART framer and its companions.
//   PAR_NONE / PAR_EVEN / PAR_ODD : parity_mode encodings (2'b11 acts as none)
//   tx_state_t                    : transmit framer states
//   DEF_CLKS_PER_BIT              : 50 MHz / 115200 baud bit period
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DEF_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer. Counts 0..CLKS_PER_BIT-1 and raises
// tick during the terminal count; clear holds the count at 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clear : restart the bit period
//   tick  : last cycle of the current bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer. Accepts one word per valid/ready
// handshake and sends start, DATA_W data bits LSB first, optional parity and
// one or two stop bits, each CLKS_PER_BIT clocks long.
//   tx_data/tx_valid/tx_ready : word handshake (ready only in IDLE)
//   parity_mode, two_stop     : frame format, latched at acceptance
//   tx_out                    : registered serial line, idle high
//   busy                      : frame in progress
//   done                      : one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W must be within 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
  end

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              stop_cnt_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              two_stop_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;

  // Timer is held at zero throughout IDLE, so the bit period starting at
  // acceptance is a full CLKS_PER_BIT long.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_valid && ready_q) begin
            shift_q    <= tx_data;
            par_en_q   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            // Parity is resolved now because the shift register is consumed later.
            par_bit_q  <= (^tx_data) ^ (parity_mode == PAR_ODD);
            two_stop_q <= two_stop;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_IDX) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              // Next bit comes out of position 1 as the register shifts.
              tx_q      <= shift_q[1];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (two_stop_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b0;
              ready_q    <= 1'b1;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_out   = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame. Instance A uses
// DATA_W=8, CLKS_PER_BIT=4; instance B uses DATA_W=5, CLKS_PER_BIT=2.
// Expected serial sequences are written out by hand, index 0 = start bit.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] a_data;
  logic       a_valid, a_ready, a_ts, a_out, a_busy, a_done;
  logic [1:0] a_pm;

  logic [4:0] b_data;
  logic       b_valid, b_ready, b_ts, b_out, b_busy, b_done;
  logic [1:0] b_pm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .parity_mode(a_pm), .two_stop(a_ts),
    .tx_out(a_out), .busy(a_busy), .done(a_done)
  );

  uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .parity_mode(b_pm), .two_stop(b_ts),
    .tx_out(b_out), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a sample point with the word already presented; the next edge
  // accepts it. Returns at the sample point of the done cycle.
  task automatic frame(input bit sel, input logic [11:0] seq, input int nbits,
                       input bit keep, input bit toggle);
    int cpb;
    cpb = sel ? 2 : 4;
    @(posedge clk); #1;
    if (!keep) begin
      a_valid = 1'b0;
      b_valid = 1'b0;
    end
    for (int c = 0; c < nbits * cpb; c++) begin
      chk($sformatf("%s_tx_out_bit%0d_cyc%0d", sel ? "b" : "a", c / cpb, c),
          sel ? b_out : a_out, seq[c / cpb]);
      if (c == 0) begin
        chk("busy_in_frame",  sel ? b_busy  : a_busy,  1'b1);
        chk("ready_in_frame", sel ? b_ready : a_ready, 1'b0);
        chk("done_in_frame",  sel ? b_done  : a_done,  1'b0);
      end
      if (toggle && c == 12) a_pm = 2'b10;
      @(posedge clk); #1;
    end
    chk("done_pulse",  sel ? b_done  : a_done,  1'b1);
    chk("ready_after", sel ? b_ready : a_ready, 1'b1);
    chk("busy_after",  sel ? b_busy  : a_busy,  1'b0);
    chk("idle_high",   sel ? b_out   : a_out,   1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    a_data  = 8'hA5; a_pm = 2'b00; a_ts = 1'b0; a_valid = 1'b1;
    b_data  = 5'h00; b_pm = 2'b00; b_ts = 1'b0; b_valid = 1'b0;

    // Reset with a word already offered
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_tx_out", a_out,   1'b1);
      chk("rst_ready",  a_ready, 1'b1);
      chk("rst_busy",   a_busy,  1'b0);
      chk("rst_done",   a_done,  1'b0);
    end
    rst_n = 1'b1;

    // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
    frame(1'b0, 12'b1101001010, 10, 1'b0, 1'b0);

    // 0xA5 even parity -> parity 0
    a_pm = 2'b01; a_valid = 1'b1;
    frame(1'b0, 12'b10101001010, 11, 1'b0, 1'b0);

    // 0xA5 odd parity -> parity 1
    a_pm = 2'b10; a_valid = 1'b1;
    frame(1'b0, 12'b11101001010, 11, 1'b0, 1'b0);

    // 0xA5 odd parity, two stops (48 cycles)
    a_ts = 1'b1; a_valid = 1'b1;
    frame(1'b0, 12'b111101001010, 12, 1'b0, 1'b0);

    // Back-to-back 0x00 then 0xFF with parity_mode toggled mid-frame
    a_ts = 1'b0; a_pm = 2'b00; a_data = 8'h00; a_valid = 1'b1;
    frame(1'b0, 12'b1000000000, 10, 1'b1, 1'b1);
    a_pm = 2'b00; a_data = 8'hFF;
    frame(1'b0, 12'b1111111110, 10, 1'b0, 1'b0);

    // Reset in the middle of DATA
    a_data = 8'h3C; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid_data_bit1", a_out, 1'b0);
    chk("mid_data_busy", a_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_out", a_out,   1'b1);
    chk("async_rst_busy",   a_busy,  1'b0);
    chk("async_rst_ready",  a_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_data = 8'h5A; a_valid = 1'b1;
    frame(1'b0, 12'b1010110100, 10, 1'b0, 1'b0);

    // DATA_W=5, CLKS_PER_BIT=2, 0x13 odd parity, two stops: 0,1,1,0,0,1,0,1,1
    b_data = 5'h13; b_pm = 2'b10; b_ts = 1'b1; b_valid = 1'b1;
    frame(1'b1, 12'b110100110, 9, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit framer. It accepts one data word per valid/ready handshake and serialises it on `tx_out` as a start bit, DATA_W data bits (LSB first), an optional parity bit and one or two stop bits, each held for CLKS_PER_BIT clocks. It sits between the host-side transmit buffer and the TX pin, and replaces fixed-format bit selection with a sequenced, configurable frame generator.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 434, clocks per bit period (50 MHz / 115200); minimum 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_W  word to send; sampled at acceptance.
- tx_valid  in  1  tx_data holds a word.
- tx_ready  out  1  framer can accept a word; high only in IDLE.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 reserved (behaves as none); sampled at acceptance.
- two_stop  in  1  1 sends two stop bits, 0 sends one; sampled at acceptance.
- tx_out  out  1  serial line; idle high.
- busy  out  1  a frame is in progress (any state other than IDLE).
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE.
- Acceptance: a word is accepted on the edge where tx_valid && tx_ready.
  - On that edge, latch tx_data, parity_mode and two_stop into a shift register and mode flags, then go to START.
  - Changes to tx_data or the mode inputs mid-frame have no effect.
- tx_out drive per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift-register LSB. Shift right once per bit period, DATA_W bits in total.
  - PARITY: even = XOR-reduce of the latched word; odd = its complement.
  - STOP: 1, for one or two bit periods.
- Bit timer: counts 0..CLKS_PER_BIT-1 and asserts a tick on its terminal count; every state transition except leaving IDLE happens on a tick.
- Bit index counts 0..DATA_W-1 in DATA; stop counter counts 0..1 in STOP.
- tx_out is registered, so there are no combinational glitches on the pin.

## Timing
- Reset values: tx_out=1, tx_ready=1, busy=0, done=0, state IDLE, counters 0, shift register 0.
- Reset asserted mid-frame abandons the frame immediately (asynchronous); tx_out returns to 1 at once.
- Latency: tx_out goes low on the first edge after acceptance.
- Frame length is (1 + DATA_W + P + S) × CLKS_PER_BIT cycles, where P is 0 or 1 and S is 1 or 2.
- done pulses in the first IDLE cycle after the last stop-bit period. tx_ready and done are high in that same cycle.
- Back-to-back: if tx_valid is held high, the next word is accepted in the done cycle. This gives exactly one extra idle-high cycle between frames.
- tx_valid asserted while busy is ignored. The source must hold the word until tx_ready.
- The bit timer is cleared on acceptance, so every bit period is exactly CLKS_PER_BIT cycles, including the first.

## Structure
- Shared package uart_pkg:
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - default CLKS_PER_BIT constant.
- Sub-module uart_baud_tick (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick). It is reused later by the receiver.
- Elaboration check: fail if DATA_W is outside 5..9 or CLKS_PER_BIT < 2.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_W=8 unless noted.
- Reset with tx_valid=1 → while rst_n=0: tx_out=1, tx_ready=1, busy=0. After release, the word is accepted on the first edge.
- Send 0xA5, no parity, one stop → tx_out reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); done pulses at cycle 41.
- Send 0xA5 with even parity, then with odd parity → parity bit is 0, then 1. Frame is 44 cycles; two_stop=1 makes it 48 cycles.
- Hold tx_valid high with words 0x00 then 0xFF → second start bit begins exactly one idle cycle after the first frame ends. Toggling parity_mode mid-frame does not alter the frame in flight.
- Pull rst_n low in the middle of DATA → tx_out=1 immediately, busy=0. The next word is sent as a complete, correct frame.
- DATA_W=5, CLKS_PER_BIT=2, word 0x13, odd parity, two stops → bits 0,1,1,0,0,1,0,1,1, each held 2 cycles (18 cycles).
